// File: rtl/nap_countdown_4bit.sv
// Nap countdown: loads a 4-bit preset, decrements it once every TICK_DIV cycles,
// and supports start/pause/resume/clear with a done level and a done pulse.
module nap_countdown_4bit #(
  parameter int TICK_DIV = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Din,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  output logic [3:0] Remain,
  output logic       Busy,
  output logic       Done,
  output logic       DonePulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    remain_q, remain_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pulse_q, pulse_d;

  // Next-state, count and output decode; outputs are derived from the next state
  // so every output leaves the block straight from a flop.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    presc_d  = presc_q;
    pulse_d  = 1'b0;

    if (Clear) begin
      state_d  = IDLE;
      remain_d = 4'd0;
      presc_d  = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            presc_d = '0;
            if (Din != 4'd0) begin
              state_d  = RUN;
              remain_d = Din;
            end else begin
              state_d  = DONE;
              remain_d = 4'd0;
              pulse_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          // Pause freezes the count even when the tick would have landed now.
          if (Pause) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d  = '0;
            remain_d = remain_q - 4'd1;
            if (remain_q == 4'd1) begin
              state_d = DONE;
              pulse_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (Start) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        default: begin
          state_d  = IDLE;
          remain_d = 4'd0;
          presc_d  = '0;
        end
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  // State, count and registered-output flops with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      remain_q <= 4'd0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pulse_q  <= pulse_d;
    end
  end

  assign Remain    = remain_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DonePulse = pulse_q;

endmodule

// File: tb/tb_nap_countdown_4bit.sv
// Directed scoreboard bench for nap_countdown_4bit with TICK_DIV=4.
module tb_nap_countdown_4bit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] Din = 4'd0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] Remain;
  logic       Busy;
  logic       Done;
  logic       DonePulse;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];

  nap_countdown_4bit #(.TICK_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .Din(Din), .Start(Start), .Pause(Pause), .Clear(Clear),
    .Remain(Remain), .Busy(Busy), .Done(Done), .DonePulse(DonePulse)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] pk(input int r, input bit b, input bit d, input bit p);
    return {4'(r), b, d, p};
  endfunction

  task automatic check(input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {Remain, Busy, Done, DonePulse};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed {Remain,Busy,Done,Pulse}=%h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input bit st, input bit pa, input bit cl, input int din,
                      input logic [6:0] exp, input string tag);
    Start = st;
    Pause = pa;
    Clear = cl;
    Din   = 4'(din);
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    check(tag);
  endtask

  initial begin
    // Power-on reset: outputs low without any clock edge.
    #3;
    exp_q.push_back(pk(0, 0, 0, 0));
    check("por");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    step(0, 0, 0, 0, pk(0, 0, 0, 0), "idle_after_rel");

    // Basic countdown, Din=3: decrements at edges 4, 8, 12.
    step(1, 0, 0, 3, pk(3, 1, 0, 0), "basic_load");
    for (int c = 1; c <= 12; c++)
      step(0, 0, 0, 3, pk(3 - c / 4, c < 12, c == 12, c == 12), "basic_run");
    step(0, 0, 0, 3, pk(0, 0, 1, 0), "basic_done_hold");

    // Restart from DONE with Din=2, then Din changes to 9 mid-run.
    step(1, 0, 0, 2, pk(2, 1, 0, 0), "restart_load");
    for (int c = 1; c <= 8; c++)
      step(0, 0, 0, 9, pk(2 - c / 4, c < 8, c == 8, c == 8), "din_isolation");

    // Zero preset from IDLE.
    step(0, 0, 1, 0, pk(0, 0, 0, 0), "clear_to_idle");
    step(1, 0, 0, 0, pk(0, 0, 1, 1), "zero_preset");
    step(0, 0, 0, 0, pk(0, 0, 1, 0), "zero_pulse_once");

    // Pause/resume: 10 frozen edges delay completion from edge 20 to edge 30.
    step(0, 0, 1, 0, pk(0, 0, 0, 0), "clear2");
    step(1, 0, 0, 5, pk(5, 1, 0, 0), "pause_load");
    for (int c = 1; c <= 30; c++) begin
      int e;
      e = (c <= 6) ? c : ((c <= 16) ? 6 : c - 10);
      step(c == 16, (c >= 7) && (c <= 16), 1'b0, 0,
           pk(5 - e / 4, c < 30, c == 30, c == 30), "pause_run");
    end

    // Clear beats Pause in RUN; Pause ignored in IDLE.
    step(1, 0, 0, 5, pk(5, 1, 0, 0), "prio_load");
    step(0, 0, 0, 5, pk(5, 1, 0, 0), "prio_run");
    step(0, 1, 1, 5, pk(0, 0, 0, 0), "clear_over_pause");
    step(0, 1, 0, 5, pk(0, 0, 0, 0), "pause_in_idle");

    // Pause on the terminal tick holds Remain=1 with no pulse.
    step(1, 0, 0, 1, pk(1, 1, 0, 0), "term_load");
    for (int c = 1; c <= 3; c++)
      step(0, 0, 0, 1, pk(1, 1, 0, 0), "term_run");
    step(0, 1, 0, 1, pk(1, 1, 0, 0), "pause_at_tick");
    step(0, 0, 0, 1, pk(1, 1, 0, 0), "term_paused");
    step(1, 0, 0, 1, pk(1, 1, 0, 0), "term_resume");
    step(0, 0, 0, 1, pk(0, 0, 1, 1), "term_done");

    // Start held through a run: ignored in RUN, restarts once in DONE.
    step(0, 0, 1, 0, pk(0, 0, 0, 0), "clear3");
    step(1, 0, 0, 1, pk(1, 1, 0, 0), "held_load");
    for (int c = 1; c <= 3; c++)
      step(1, 0, 0, 1, pk(1, 1, 0, 0), "held_run");
    step(1, 0, 0, 1, pk(0, 0, 1, 1), "held_done");
    step(1, 0, 0, 1, pk(1, 1, 0, 0), "held_restart");

    // Reset mid-run abandons the count asynchronously.
    step(0, 0, 1, 0, pk(0, 0, 0, 0), "clear4");
    step(1, 0, 0, 5, pk(5, 1, 0, 0), "rst_load");
    for (int c = 1; c <= 6; c++)
      step(0, 0, 0, 5, pk(5 - c / 4, 1, 0, 0), "rst_run");
    #2;
    RST = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0));
    #1;
    check("async_reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int c = 0; c < 3; c++)
      step(0, 0, 0, 5, pk(0, 0, 0, 0), "idle_post_reset");
    step(1, 0, 0, 2, pk(2, 1, 0, 0), "start_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nap_countdown_4bit.md
# nap_countdown_4bit

Downstream consumer of the 4-bit clock-enabled setpoint register. Takes the stored 4-bit value (nap length in units) as a preset, counts it down at one unit per `TICK_DIV` clock cycles, and supports start, pause/resume and clear controls. It flags completion with a level and a single-cycle pulse for the alarm and display stages. It is fully synchronous to one clock.

## Interface

Parameters:
- `TICK_DIV`, default 1000: clock cycles per unit decrement. Must be ≥ 2. The prescaler width is $clog2(TICK_DIV).

Ports:
- `CLK`, input, 1: system clock. Rising edge active.
- `RST`, input, 1: reset. Asynchronous and active-low.
- `Din`, input, 4: preset value, driven from the setpoint register output. Sampled only on an accepted load.
- `Start`, input, 1: start, resume or restart request. Level sampled each edge.
- `Pause`, input, 1: pause request. Level sampled each edge.
- `Clear`, input, 1: synchronous abort to IDLE.
- `Remain`, output, 4: current remaining count. Registered.
- `Busy`, output, 1: high in RUN or PAUSE.
- `Done`, output, 1: high while in DONE.
- `DonePulse`, output, 1: one-cycle pulse on entry to DONE.

## Operation

- States (2-bit): IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Control priority, evaluated every edge: Clear > Pause > Start > prescaler tick.
- Clear, from any state: go to IDLE, Remain=0, prescaler=0, DonePulse=0.
- **IDLE**
  - Start with Din≠0: Remain←Din, prescaler←0, go to RUN.
  - Start with Din=0: go to DONE, DonePulse=1, Remain stays 0.
  - Pause is ignored.
- **RUN**
  - Pause: go to PAUSE. Prescaler and Remain hold, even if a tick was due this cycle.
  - Otherwise the prescaler increments.
  - When prescaler = TICK_DIV−1: prescaler←0 and Remain←Remain−1.
  - If Remain was 1 at that tick: go to DONE with DonePulse=1.
  - Start is ignored.
- **PAUSE**
  - Start: go to RUN. The prescaler resumes from its held value, so no partial unit is lost or repeated.
  - Pause is ignored.
- **DONE**
  - Remain=0 and Done=1.
  - Start: restart exactly as from IDLE, using the current Din. Done drops on the next edge.
  - Pause is ignored.
- Din is not observed outside load cycles. Changes to Din during RUN or PAUSE have no effect.
- Remain never wraps. A decrement below 0 is unreachable by construction.

## Timing

- Reset values, all applied immediately on RST low regardless of CLK:
  - State = IDLE
  - Remain = 0, Busy = 0, Done = 0, DonePulse = 0
  - Prescaler = 0
- Release of RST is synchronous to CLK: the first active edge follows deassertion.
- RST low mid-run abandons the count. No DonePulse is produced.
- All outputs are registered. Outputs decode from the state register, with no combinational input-to-output paths.
- Start accepted at edge k:
  - Busy=1 and Remain=Din after edge k.
  - First decrement at edge k+TICK_DIV. Each subsequent decrement follows TICK_DIV RUN cycles later.
  - Remain=0, Done=1 and DonePulse=1 after edge k+Din·TICK_DIV, provided there is no pause.
- Each PAUSE cycle extends completion by exactly one cycle.
- DonePulse is high for exactly one cycle per completion. Holding Start in DONE restarts every cycle it is seen.
- Start held high through a run has no effect until DONE, where it restarts.

## Test plan

With TICK_DIV=4 unless noted:

1. **Reset mid-run.** Din=5, Start, then RST low at cycle 6 → all outputs 0 asynchronously. After release, the block stays IDLE until a new Start.
2. **Basic countdown.** Din=3, Start pulse at edge 0 → Remain=3 after edge 0, 2 at edge 4, 1 at edge 8, 0 at edge 12. At edge 12, Done=1 and DonePulse=1 for one cycle only. Busy falls at edge 12.
3. **Pause/resume.** Din=5, Start at edge 0, Pause at edge 6 (Remain=4, prescaler=2) held for 10 cycles → Remain stays 4. Then Start → Remain=3 two RUN cycles after resume, and completion is 10 cycles later than in the unpaused run.
4. **Zero preset.** Din=0 with Start in IDLE → DONE at the next edge, DonePulse for one cycle, Remain=0, Busy never asserts.
5. **Priority.** Clear and Pause together in RUN → IDLE, Remain=0. Pause coincident with the terminal tick (Remain=1, prescaler=3) → PAUSE with Remain=1 and no DonePulse.
6. **Restart and Din isolation.** From DONE, Start with Din=2 → Done=0 and Remain=2 next edge. Changing Din to 9 during RUN leaves the count unaffected, completing 8 cycles after the restart.
